// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter
//   SPI target-side serial engine. It synchronizes the pad SCK/NSS/MOSI into
//   clk_i, detects sample and shift edges for all four CPOL/CPHA modes, and
//   moves 8-bit frames between the pads and valid/ready byte interfaces.
//
// Ports
//   clk_i, rst_n_i            system clock, async active-low reset
//   en_i                      block enable (low forces IDLE, edges ignored)
//   cpol_i, cpha_i, lsb_i     mode select (change only while idle)
//   spi_sck_i/nss_i/mosi_i    asynchronous pad inputs
//   spi_miso_o, spi_miso_en_o MISO data and pad output-enable
//   tx_data_i/valid_i/ready_o tx holding-register handshake
//   rx_data_o/valid_o/ready_i received-byte handshake
//   rx_overrun_o              pulse: completed byte dropped (rx still full)
//   tx_underrun_o             pulse: 8'hFF loaded because holding was empty
//   busy_o                    frame in progress
module spi_slave_shifter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       lsb_i,
  input  logic       spi_sck_i,
  input  logic       spi_nss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
  logic [SYNC_STAGES-1:0] nss_sync_q,  nss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_dly_q,   sck_dly_d;
  logic                   nss_dly_q,   nss_dly_d;

  logic [0:0] state_q,     state_d;
  logic [2:0] cnt_q,       cnt_d;
  logic [7:0] rx_shift_q,  rx_shift_d;
  logic [7:0] tx_shift_q,  tx_shift_d;
  logic [7:0] hold_q,      hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q,   rx_data_d;
  logic       rx_valid_q,  rx_valid_d;
  logic       rx_ovr_q,    rx_ovr_d;
  logic       tx_und_q,    tx_und_d;
  logic       miso_q,      miso_d;
  logic       miso_en_q,   miso_en_d;

  logic       sck_s, nss_s, mosi_s;
  logic       sck_rise, sck_fall, nss_rise, nss_fall;
  logic       lead_edge, trail_edge, sample_edge, shift_edge;
  logic       tx_load, capture;
  logic [7:0] rx_byte;

  // MOSI shares the SCK synchronizer depth, so the MOSI value seen on the
  // cycle an SCK edge is detected is the pad level at that pad edge.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  spi_sck_i};
    nss_sync_d  = {nss_sync_q[SYNC_STAGES-2:0],  spi_nss_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    nss_s       = nss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sck_dly_d   = sck_s;
    nss_dly_d   = nss_s;
    sck_rise    = sck_s & ~sck_dly_q;
    sck_fall    = ~sck_s & sck_dly_q;
    nss_rise    = nss_s & ~nss_dly_q;
    nss_fall    = ~nss_s & nss_dly_q;
    lead_edge   = cpol_i ? sck_fall : sck_rise;
    trail_edge  = cpol_i ? sck_rise : sck_fall;
    sample_edge = cpha_i ? trail_edge : lead_edge;
    shift_edge  = cpha_i ? lead_edge  : trail_edge;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_ovr_d    = 1'b0;
    tx_und_d    = 1'b0;
    tx_load     = 1'b0;
    capture     = tx_valid_i & ~hold_full_q;
    rx_byte     = lsb_i ? {mosi_s, rx_shift_q[7:1]} : {rx_shift_q[6:0], mosi_s};

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_i && nss_fall) begin
          state_d    = ST_ACTIVE;
          cnt_d      = '0;
          rx_shift_d = '0;
          // CPHA=0 must present bit 0 before the first (sampling) edge;
          // CPHA=1 loads on the first leading edge instead.
          if (!cpha_i) tx_load    = 1'b1;
          else         tx_shift_d = '1;
        end
      end
      default: begin
        if (!en_i || nss_rise) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          rx_shift_d = '0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = rx_byte;
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // A consumer acknowledging in the same cycle frees the slot.
              if (!rx_valid_q || rx_ready_i) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
              end else begin
                rx_ovr_d   = 1'b1;
              end
            end
          end
          if (shift_edge) begin
            if (cnt_q == 3'd0) tx_load = 1'b1;
            else if (lsb_i)    tx_shift_d = {1'b1, tx_shift_q[7:1]};
            else               tx_shift_d = {tx_shift_q[6:0], 1'b1};
          end
        end
      end
    endcase

    if (tx_load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d  = '1;
        tx_und_d    = 1'b1;
      end
    end

    // Capture only happens when holding is empty, so a simultaneous load
    // has already sent 8'hFF and the new byte waits for the next load.
    if (capture) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    miso_d    = lsb_i ? tx_shift_d[0] : tx_shift_d[7];
    miso_en_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_q  <= '0;
      nss_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      nss_dly_q   <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_und_q    <= 1'b0;
      miso_q      <= 1'b1;
      miso_en_q   <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      nss_sync_q  <= nss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_dly_q   <= sck_dly_d;
      nss_dly_q   <= nss_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_und_q    <= tx_und_d;
      miso_q      <= miso_d;
      miso_en_q   <= miso_en_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_en_o = miso_en_q;
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_ovr_q;
  assign tx_underrun_o = tx_und_q;
  assign busy_o        = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb_spi_slave_shifter
//   Directed bench for spi_slave_shifter acting as an SPI master with
//   hand-computed expected bytes, pulse counts and reset values.
module tb_spi_slave_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic       sck = 1'b0, nss = 1'b1, mosi = 1'b0;
  logic       miso, miso_en;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       rx_overrun, tx_underrun, busy;

  int total = 0;
  int bad   = 0;
  int n_rxv = 0, n_und = 0, n_ovr = 0;
  logic rv_prev = 1'b0;

  always #5 clk = ~clk;

  spi_slave_shifter #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb),
    .spi_sck_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_en_o(miso_en),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_overrun_o(rx_overrun), .tx_underrun_o(tx_underrun), .busy_o(busy)
  );

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && !rv_prev) n_rxv++;
      if (tx_underrun) n_und++;
      if (rx_overrun)  n_ovr++;
    end
    rv_prev = rx_valid;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h, input logic l);
    cpol = p; cpha = h; lsb = l; sck = p;
    repeat (4) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("tx_ready_wait", 8'(tx_ready), 8'h01);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic frame_start();
    nss = 1'b0;
    half();
  endtask

  task automatic frame_end();
    half();
    nss = 1'b1;
    half();
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    int b;
    mi = '1;
    for (int i = 0; i < nbits; i++) begin
      b = lsb ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[b]; half(); mi[b] = miso; sck = ~cpol; half(); sck = cpol;
      end else begin
        sck = ~cpol; mosi = mo[b]; half(); mi[b] = miso; sck = cpol; half();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mi, m1, m2;
    int r0, u0, o0;
    logic [1:0] modes [3];
    modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso",     8'(miso),        8'h01);
    check("rst_miso_en",  8'(miso_en),     8'h00);
    check("rst_tx_ready", 8'(tx_ready),    8'h01);
    check("rst_rx_data",  rx_data,         8'h00);
    check("rst_rx_valid", 8'(rx_valid),    8'h00);
    check("rst_overrun",  8'(rx_overrun),  8'h00);
    check("rst_underrun", 8'(tx_underrun), 8'h00);
    check("rst_busy",     8'(busy),        8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0, MSB first; a filler byte keeps the final trailing-edge load fed.
    set_mode(1'b0, 1'b0, 1'b0);
    push_tx(8'hA5);
    r0 = n_rxv; u0 = n_und;
    frame_start();
    check("m0_busy",    8'(busy),    8'h01);
    check("m0_miso_en", 8'(miso_en), 8'h01);
    push_tx(8'h00);
    xfer(8'h3C, 8, mi);
    frame_end();
    check("m0_rx",      rx_data,      8'h3C);
    check("m0_miso",    mi,           8'hA5);
    check("m0_nvalid",  8'(n_rxv - r0), 8'h01);
    check("m0_nunder",  8'(n_und - u0), 8'h00);
    check("m0_idle_en", 8'(miso_en),  8'h00);

    // Modes 1/2/3, LSB first.
    foreach (modes[k]) begin
      set_mode(modes[k][1], modes[k][0], 1'b1);
      push_tx(8'h81);
      r0 = n_rxv; u0 = n_und;
      frame_start();
      if (!cpha) push_tx(8'h00);
      xfer(8'h96, 8, mi);
      frame_end();
      check($sformatf("mode%0d_rx", k + 1),     rx_data,        8'h96);
      check($sformatf("mode%0d_miso", k + 1),   mi,             8'h81);
      check($sformatf("mode%0d_nvalid", k + 1), 8'(n_rxv - r0), 8'h01);
      check($sformatf("mode%0d_nunder", k + 1), 8'(n_und - u0), 8'h00);
    end

    // Two-byte frame, holding filled only for byte 1 (mode 1, MSB first).
    set_mode(1'b0, 1'b1, 1'b0);
    push_tx(8'hB1);
    u0 = n_und;
    frame_start();
    xfer(8'h11, 8, m1);
    xfer(8'h22, 8, m2);
    frame_end();
    check("two_miso_b1", m1, 8'hB1);
    check("two_miso_b2", m2, 8'hFF);
    check("two_nunder",  8'(n_und - u0), 8'h01);
    check("two_rx",      rx_data, 8'h22);

    // Overrun: two bytes with the consumer stalled.
    rx_ready = 1'b0;
    o0 = n_ovr;
    frame_start();
    xfer(8'hC3, 8, mi);
    xfer(8'h5A, 8, mi);
    frame_end();
    check("ovr_rx",    rx_data, 8'hC3);
    check("ovr_novr",  8'(n_ovr - o0), 8'h01);
    check("ovr_valid", 8'(rx_valid), 8'h01);
    rx_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("ovr_cleared", 8'(rx_valid), 8'h00);

    // Partial byte aborted by NSS, then a clean frame.
    set_mode(1'b0, 1'b0, 1'b0);
    r0 = n_rxv;
    frame_start();
    xfer(8'hAA, 5, mi);
    frame_end();
    check("part_nvalid",  8'(n_rxv - r0), 8'h00);
    check("part_miso_en", 8'(miso_en), 8'h00);
    check("part_busy",    8'(busy), 8'h00);
    frame_start();
    xfer(8'h55, 8, mi);
    frame_end();
    check("after_part_rx",     rx_data, 8'h55);
    check("after_part_nvalid", 8'(n_rxv - r0), 8'h01);

    // Disabled block ignores NSS.
    en = 1'b0;
    nss = 1'b0;
    repeat (10) @(negedge clk);
    check("dis_busy",    8'(busy), 8'h00);
    check("dis_miso_en", 8'(miso_en), 8'h00);
    nss = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b1;

    // Reset in the middle of a frame.
    frame_start();
    xfer(8'hF0, 3, mi);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",     8'(busy),     8'h00);
    check("mid_rst_miso",     8'(miso),     8'h01);
    check("mid_rst_miso_en",  8'(miso_en),  8'h00);
    check("mid_rst_rx_data",  rx_data,      8'h00);
    check("mid_rst_tx_ready", 8'(tx_ready), 8'h01);
    nss = 1'b1; sck = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", 8'(busy), 8'h00);
    frame_start();
    check("post_rst_frame_busy", 8'(busy), 8'h01);
    nss = 1'b1;
    half();
    check("post_rst_end_busy", 8'(busy), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
